// File: rtl/left_shift_reg.sv
// Left shift register: parallel load, serial shift-in at the LSB, synchronous clear.
// Define LEFT_SHIFT_REG_SOUT_EN to add a registered serial-out port (sout) after q.
module left_shift_reg #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          async_rst,
    input  logic          load,
    input  logic          en,
    input  logic [DW-1:0] data,
    input  logic          data_l,
    output logic [DW-1:0] q
`ifdef LEFT_SHIFT_REG_SOUT_EN
    ,
    output logic          sout
`endif
);

    logic [DW-1:0] q_q;
    logic [DW-1:0] q_d;
    logic [DW-1:0] shifted;

    // Bit 0 takes the serial input; every other bit takes its lower neighbour.
    assign shifted[0] = data_l;
    for (genvar gi = 1; gi < DW; gi++) begin : g_shift
        assign shifted[gi] = q_q[gi-1];
    end

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = data;
        end else if (en) begin
            q_d = shifted;
        end
    end

    always_ff @(posedge clk) begin
        if (async_rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

`ifdef LEFT_SHIFT_REG_SOUT_EN
    logic sout_q;
    logic sout_d;

    // sout captures the bit pushed out of the MSB; a load clears it.
    always_comb begin
        sout_d = sout_q;
        if (load) begin
            sout_d = 1'b0;
        end else if (en) begin
            sout_d = q_q[DW-1];
        end
    end

    always_ff @(posedge clk) begin
        if (async_rst) begin
            sout_q <= 1'b0;
        end else begin
            sout_q <= sout_d;
        end
    end

    assign sout = sout_q;
`endif

endmodule

// File: tb/tb_left_shift_reg.sv
// Self-checking bench for left_shift_reg (DW=4): directed cases followed by random
// traffic against an arithmetic reference model. Checks sout when LEFT_SHIFT_REG_SOUT_EN is set.
module tb_left_shift_reg;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          async_rst = 1'b0;
    logic          load = 1'b0;
    logic          en = 1'b0;
    logic [DW-1:0] data = '0;
    logic          data_l = 1'b0;
    logic [DW-1:0] q;
`ifdef LEFT_SHIFT_REG_SOUT_EN
    logic          sout;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: register value as a plain integer, serial-out as an int.
    int m_val  = 0;
    int m_sout = 0;

    always #5 clk = ~clk;

    left_shift_reg #(.DW(DW)) dut (
        .clk       (clk),
        .async_rst (async_rst),
        .load      (load),
        .en        (en),
        .data      (data),
        .data_l    (data_l),
        .q         (q)
`ifdef LEFT_SHIFT_REG_SOUT_EN
        ,
        .sout      (sout)
`endif
    );

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one edge's worth of inputs, advance past the edge, update model, compare.
    task automatic step(input logic r, input logic l, input logic e,
                        input logic [DW-1:0] d, input logic dl, input string tag);
        logic [DW-1:0] exp_q;
        async_rst = r;
        load      = l;
        en        = e;
        data      = d;
        data_l    = dl;
        @(posedge clk);
        #1;
        if (r) begin
            m_val  = 0;
            m_sout = 0;
        end else if (l) begin
            m_val  = int'(d);
            m_sout = 0;
        end else if (e) begin
            m_sout = (m_val / (2 ** (DW - 1))) % 2;
            m_val  = (m_val * 2 + int'(dl)) % (2 ** DW);
        end
        exp_q = m_val[DW-1:0];
        chk(tag, q, exp_q);
`ifdef LEFT_SHIFT_REG_SOUT_EN
        chk({tag, "_sout"}, {{(DW-1){1'b0}}, sout}, m_sout[DW-1:0]);
`endif
        $display("[TB] %-10s rst=%b load=%b en=%b data=%h dl=%b -> q=%h", tag, r, l, e, d, dl, q);
    endtask

    initial begin
        logic [DW-1:0] held;
        logic [DW-1:0] shift_exp [4];
        logic          shift_bits [4];
        shift_exp  = '{4'h3, 4'h6, 4'hD, 4'hB};
        shift_bits = '{1'b1, 1'b0, 1'b1, 1'b1};

        // Reset wins over load.
        step(1'b1, 1'b1, 1'b0, 4'hF, 1'b0, "reset");
        chk("reset_lit", q, 4'h0);

        // Load then hold while data wanders.
        step(1'b0, 1'b1, 1'b0, 4'hA, 1'b0, "load");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 4'(i * 5 + 1), 1'(i), "hold");
            chk("hold_lit", q, 4'hA);
        end

        // Four consecutive shifts from 9.
        step(1'b0, 1'b1, 1'b0, 4'h9, 1'b0, "load9");
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1, 4'h0, shift_bits[i], "shift");
            chk("shift_lit", q, shift_exp[i]);
        end

        // Load beats shift.
        step(1'b0, 1'b1, 1'b0, 4'h5, 1'b0, "load5");
        step(1'b0, 1'b1, 1'b1, 4'hC, 1'b1, "prio");
        chk("prio_lit", q, 4'hC);

        // Reset in the middle of shifting, then resume from zero.
        step(1'b0, 1'b1, 1'b0, 4'h7, 1'b0, "load7");
        step(1'b0, 1'b0, 1'b1, 4'h0, 1'b1, "shift");
        step(1'b1, 1'b0, 1'b1, 4'h0, 1'b1, "midrst");
        chk("midrst_lit", q, 4'h0);
        step(1'b0, 1'b0, 1'b1, 4'h0, 1'b1, "resume");
        chk("resume_lit", q, 4'h1);

        // Inputs changed between edges must not reach q; a reset pulse between edges is ignored.
        step(1'b0, 1'b1, 1'b0, 4'h6, 1'b0, "load6");
        held      = q;
        async_rst = 1'b1;
        load      = 1'b1;
        data      = 4'h9;
        #2;
        chk("no_comb", q, 4'h6);
        async_rst = 1'b0;
        load      = 1'b0;
        #1;
        step(1'b0, 1'b0, 1'b0, 4'h3, 1'b1, "glitch");
        chk("glitch_lit", q, held);

`ifdef LEFT_SHIFT_REG_SOUT_EN
        step(1'b0, 1'b1, 1'b0, 4'h8, 1'b0, "load8");
        step(1'b0, 1'b0, 1'b1, 4'h0, 1'b0, "sout_sh");
        chk("sout_sh_q", q, 4'h0);
        chk("sout_sh_s", {3'b000, sout}, 4'h1);
        step(1'b0, 1'b1, 1'b0, 4'h3, 1'b0, "sout_ld");
        chk("sout_ld_q", q, 4'h3);
        chk("sout_ld_s", {3'b000, sout}, 4'h0);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)),
                 4'($urandom),
                 1'($urandom_range(0, 1)),
                 "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
